// File: rtl/mux_pkg.sv
// Shared constants for the channel mux/arbiter: mode encodings, output-register
// state and the select-width helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Channel-index width; a 1-bit index is kept even for degenerate counts.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester at or after base, wrapping mod N.
module rr_pick #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] base,
  output logic [SEL_W-1:0] grant,
  output logic             grant_valid
);

  logic [SEL_W-1:0] w_idx;

  assign grant_valid = |req;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    grant = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = SEL_W'((int'(base) + k) % N);
      if (req[w_idx]) grant = w_idx;
    end
  end

endmodule

// File: rtl/mux_arb.sv
// N-channel valid/ready mux with fixed-select or round-robin arbitration feeding
// a single-entry output register.
module mux_arb
  import mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 8,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_e           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ptr, r_ch;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] w_rr_grant, w_grant, w_ptr_nxt;
  logic [WIDTH-1:0] w_grant_data;
  logic             w_rr_valid, w_fixed_valid, w_grant_valid, w_load;

  rr_pick #(.N(N_CH), .SEL_W(SEL_W)) u_pick (
    .req         (in_valid),
    .base        (r_ptr),
    .grant       (w_rr_grant),
    .grant_valid (w_rr_valid)
  );

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    w_fixed_valid = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (int'(sel) == i) w_fixed_valid = in_valid[i];
  end

  assign w_grant       = (mode == MODE_RR) ? w_rr_grant : sel;
  assign w_grant_valid = (mode == MODE_RR) ? w_rr_valid : w_fixed_valid;
  assign w_load        = !rst && w_grant_valid && (r_state == ST_EMPTY || out_ready);
  assign w_ptr_nxt     = (int'(w_rr_grant) == N_CH - 1) ? '0 : w_rr_grant + SEL_W'(1);

  always_comb begin
    in_ready     = '0;
    w_grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(w_grant) == i) begin
        w_grant_data = in_data[i*WIDTH +: WIDTH];
        in_ready[i]  = w_load;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_load)         w_state_nxt = ST_FULL;
    else if (out_ready) w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // The pointer only advances on round-robin loads; fixed-mode traffic leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_ch   <= '0;
      r_ptr  <= '0;
    end else if (w_load) begin
      r_data <= w_grant_data;
      r_ch   <= w_grant;
      if (mode == MODE_RR) r_ptr <= w_ptr_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = (r_state == ST_FULL);

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: directed scenarios plus randomized traffic
// against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_mux_arb;

  localparam int N = 8;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, mode, out_ready, out_valid;
  logic [2:0]     sel, out_ch;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;

  logic           rst5, mode5, out_ready5, out_valid5;
  logic [2:0]     sel5, out_ch5;
  logic [39:0]    in_data5;
  logic [4:0]     in_valid5, in_ready5;
  logic [7:0]     out_data5;

  mux_arb #(.N_CH(8), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_arb #(.N_CH(5), .WIDTH(8)) dut5 (
    .clk(clk), .rst(rst5), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .mode(mode5), .sel(sel5), .out_data(out_data5), .out_ch(out_ch5),
    .out_valid(out_valid5), .out_ready(out_ready5)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_q[$];   // {data, channel} of accepted words, oldest first
  int          seen[$];    // channels consumed downstream, for directed sequence checks
  bit          m_full = 1'b0;
  int          m_ptr  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rules: fixed mode grants sel if it requests; round-robin grants
  // the first requester found scanning from the pointer upward with wrap.
  function automatic void ref_grant(input logic md, input int s, input logic [N-1:0] v,
                                    input int p, output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (md == 1'b0) begin
      g  = s;
      gv = (s < N) && v[s];
    end else begin
      for (int k = 0; k < N; k++)
        if (!gv && v[(p + k) % N]) begin
          gv = 1'b1;
          g  = (p + k) % N;
        end
    end
  endfunction

  always @(negedge clk) begin : producer
    bit           gv;
    int           g;
    bit           ld;
    logic [N-1:0] er;
    gv = 1'b0; g = 0; ld = 1'b0; er = '0;
    if (!rst) begin
      ref_grant(mode, int'(sel), in_valid, m_ptr, gv, g);
      ld = gv && (!m_full || out_ready);
      if (ld) er = N'(1 << g);
    end
    chk("in_ready", in_ready, er);
    chk("out_valid", out_valid, m_full);
    if (rst) begin
      exp_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
    end else if (ld) begin
      exp_q.push_back({in_data[g*W +: W], 3'(g)});
      m_full = 1'b1;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected actual=ch%0d expected=no word at %0t", out_ch, $time);
      end else begin
        chk("out_data", out_data, exp_q[0][10:3]);
        chk("out_ch", out_ch, exp_q[0][2:0]);
        if (out_ready) begin
          seen.push_back(int'(out_ch));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] held;
    int         exp37[5];
    exp37 = '{6, 7, 0, 7, 0};

    rst = 1'b1; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
    in_data = {$urandom, $urandom};
    rst5 = 1'b1; mode5 = 1'b0; sel5 = '0; in_valid5 = '0; out_ready5 = 1'b1; in_data5 = '0;

    // Reset held three cycles with every channel requesting.
    repeat (3) tick();
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);

    // Round-robin streaming, ten back-to-back words.
    seen.delete();
    rst = 1'b0;
    tick();
    chk("first_after_rst", out_valid, 1);
    repeat (9) tick();
    in_valid = '0;
    tick();
    chk("rr_count", seen.size(), 10);
    for (int k = 0; k < 10; k++)
      chk("rr_seq", (k < seen.size()) ? seen[k] : -1, k % 8);

    // Fixed select of channel 5.
    mode = 1'b0; sel = 3'd5; in_valid = '1; in_data[5*W +: W] = 8'hA5;
    #1 chk("fixed_in_ready", in_ready, 8'h20);
    tick();
    chk("fixed_data", out_data, 8'hA5);
    chk("fixed_ch", out_ch, 5);
    in_valid = '0;
    tick();

    // Pointer parked at 7, then channels 7 and 0 alternate.
    seen.delete();
    mode = 1'b1; in_valid = 8'h40;
    tick();
    in_valid = 8'h81;
    repeat (4) tick();
    in_valid = '0;
    tick();
    chk("rr70_count", seen.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("rr70_seq", (k < seen.size()) ? seen[k] : -1, exp37[k]);

    // Backpressure: hold the word for four cycles, then resume.
    seen.delete();
    in_valid = '1; in_data = {$urandom, $urandom};
    tick();
    held = out_data;
    out_ready = 1'b0;
    repeat (4) begin
      in_data = {$urandom, $urandom};
      #1 chk("stall_in_ready", in_ready, 0);
      tick();
      chk("stall_hold", out_data, held);
    end
    out_ready = 1'b1;
    repeat (2) begin
      in_data = {$urandom, $urandom};
      tick();
    end
    in_valid = '0;
    tick();
    chk("stall_count", seen.size(), 3);

    // Randomized traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 1) == 1) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = {$urandom, $urandom};
      tick();
    end
    rst = 1'b0; in_valid = '0; out_ready = 1'b1;
    repeat (2) tick();
    chk("drain_empty", exp_q.size(), 0);

    // Five-channel instance: out-of-range select never grants, pointer untouched.
    rst5 = 1'b0; sel5 = 3'd2; in_valid5 = '1; in_data5 = {8'h0, $urandom};
    #1 chk("n5_fixed_ready", in_ready5, 5'b00100);
    tick();
    chk("n5_loaded", out_valid5, 1);
    chk("n5_loaded_ch", out_ch5, 2);
    sel5 = 3'd6;
    #1 chk("n5_oob_ready", in_ready5, 0);
    tick();
    repeat (3) begin
      chk("n5_drained", out_valid5, 0);
      chk("n5_oob_idle", in_ready5, 0);
      tick();
    end
    mode5 = 1'b1;
    #1 chk("n5_ptr_ready", in_ready5, 5'b00001);
    tick();
    chk("n5_ptr_ch", out_ch5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 SHALL have parameter N_CH, default 8, meaning number of input channels (2..32).
REQ-002 SHALL have parameter WIDTH, default 8, meaning data bits per channel.
REQ-003 SHALL have derived localparam SEL_W = max(1, clog2(N_CH)), meaning select/channel-index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-006 SHALL have port in_data, input, N_CH*WIDTH, channel i occupying bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, N_CH, the per-channel data-valid signal.
REQ-008 SHALL have port in_ready, output, N_CH, the per-channel accept strobe (combinational).
REQ-009 SHALL have port mode, input, 1, selecting 0 = MODE_FIXED (use sel) or 1 = MODE_RR (round-robin).
REQ-010 SHALL have port sel, input, SEL_W, the channel index used in MODE_FIXED.
REQ-011 SHALL have port out_data, output, WIDTH, the registered selected data.
REQ-012 SHALL have port out_ch, output, SEL_W, the index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid, output, 1, set while the output register holds data.
REQ-014 SHALL have port out_ready, input, 1, the downstream accept signal.

Function
REQ-015 SHALL implement a single-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL compute load = (EMPTY or (out_valid and out_ready)) and grant_valid.
REQ-017 In MODE_FIXED, grant_valid SHALL be in_valid[sel] and sel<N_CH, with grant = sel.
REQ-018 In MODE_FIXED with sel>=N_CH, there SHALL be no grant; out_valid falls once the held word is consumed.
REQ-019 In MODE_RR, grant SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ... mod N_CH; grant_valid SHALL be |in_valid.
REQ-020 in_ready SHALL be one-hot at grant when load=1, and all-zero otherwise; a transfer on channel i SHALL occur iff in_valid[i] and in_ready[i].
REQ-021 On load, out_data/out_ch SHALL capture in_data[grant]/grant on the next edge, giving one-cycle latency from accept to out_valid.
REQ-022 If out_valid and out_ready and not grant_valid, the block SHALL go EMPTY next cycle.
REQ-023 Simultaneous consume and load SHALL sustain one word per cycle with no bubble.
REQ-024 While FULL and out_ready=0, out_data/out_ch SHALL be held stable and in_ready SHALL be all-zero.
REQ-025 ptr SHALL update to (grant+1) mod N_CH on each MODE_RR load, wrapping from N_CH-1 to 0, and SHALL hold otherwise, including in MODE_FIXED.
REQ-026 A change of mode or sel SHALL affect only the next grant and SHALL never alter a held word.
REQ-027 in_ready SHALL be independent of in_ready of other channels (no combinational loop); in_ready MAY depend on in_valid and out_ready.

Reset
REQ-028 While rst=1 at an edge: out_valid=0, out_data=0, out_ch=0, ptr=0, state EMPTY.
REQ-029 While rst=1, in_ready SHALL be all-zero; a held word SHALL be discarded if rst asserts mid-operation.
REQ-030 On the first edge after rst deasserts, the block SHALL accept input when load conditions hold.

Structure
REQ-031 Package mux_pkg SHALL hold MODE_FIXED/MODE_RR constants and a clog2-based SEL_W function.
REQ-032 The rotating-priority search SHALL live in sub-module rr_pick (inputs: req vector and base; outputs: grant index and grant_valid), purely combinational.
REQ-033 The output register and ptr SHALL live in mux_arb.

Verification
REQ-034 Bench SHALL cover: rst held 3 cycles with in_valid=8'hFF -> in_ready=0 and out_valid=0 throughout, then out_valid=1 one cycle after release.
REQ-035 Bench SHALL cover: MODE_FIXED, sel=5, ch5=8'hA5, out_ready=1 -> out_data=8'hA5 and out_ch=5 one cycle later, and in_ready=8'h20.
REQ-036 Bench SHALL cover: MODE_RR, in_valid=8'hFF, out_ready=1 for 10 cycles -> out_ch sequence 0,1,...,7,0,1 with no bubbles.
REQ-037 Bench SHALL cover: MODE_RR, in_valid=8'b1000_0001, ptr=7 -> grants 7,0,7,0 alternating.
REQ-038 Bench SHALL cover: FULL with out_ready=0 for 4 cycles -> out_data held, in_ready=0, then resume with no data lost or duplicated.
REQ-039 Bench SHALL cover: N_CH=5, MODE_FIXED, sel=6 -> no grant, out_valid=0 after drain, ptr unchanged.
